// File: rtl/axi_lite_arbiter_2to1_if.sv
// AXI4-Lite channel bundle shared by the arbiter's upstream and downstream ports.
// The s modport is the slave-facing view and the m modport is the master-facing view.
interface axi4_lite_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;

  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;

  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;

  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport s (
    input  awaddr, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arprot, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );

  modport m (
    output awaddr, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arprot, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );
endinterface

// File: rtl/axi_lite_arbiter_2to1.sv
// Two-master to one-slave AXI4-Lite arbiter: one transaction at a time, 4-way round robin
// over {s0 write, s0 read, s1 write, s1 read}, channels forwarded combinationally once granted.
module axi_lite_arbiter_2to1 #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic   aclk,
  input  logic   areset,
  axi4_lite_if.s s0,
  axi4_lite_if.s s1,
  axi4_lite_if.m m
);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE,
    WR_XFER,
    WR_RESP,
    RD_ADDR,
    RD_RESP
  } state_t;

  state_t      state;
  logic [1:0]  rr_ptr;
  logic        gnt;
  logic        aw_done;
  logic        w_done;

  logic [3:0]  req;
  logic        pick_valid;
  logic [1:0]  pick_idx;

  logic        in_wx;
  logic        in_wb;
  logic        in_ra;
  logic        in_rr;

  logic        aw_hs;
  logic        w_hs;
  logic        b_hs;
  logic        ar_hs;
  logic        r_hs;

  logic [ADDR_W-1:0] g_awaddr;
  logic [2:0]        g_awprot;
  logic              g_awvalid;
  logic [DATA_W-1:0] g_wdata;
  logic [STRB_W-1:0] g_wstrb;
  logic              g_wvalid;
  logic              g_bready;
  logic [ADDR_W-1:0] g_araddr;
  logic [2:0]        g_arprot;
  logic              g_arvalid;
  logic              g_rready;

  // Only AW and AR raise requests; a lone W waits until its AW arrives.
  assign req = {s1.arvalid, s1.awvalid, s0.arvalid, s0.awvalid};

  // Scan downwards so the candidate closest to rr_ptr is the one left standing.
  always_comb begin
    logic [1:0] cand;
    pick_valid = 1'b0;
    pick_idx   = rr_ptr;
    cand       = rr_ptr;
    for (int i = 3; i >= 0; i--) begin
      cand = rr_ptr + 2'(i);
      if (req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    if (gnt) begin
      g_awaddr  = s1.awaddr;
      g_awprot  = s1.awprot;
      g_awvalid = s1.awvalid;
      g_wdata   = s1.wdata;
      g_wstrb   = s1.wstrb;
      g_wvalid  = s1.wvalid;
      g_bready  = s1.bready;
      g_araddr  = s1.araddr;
      g_arprot  = s1.arprot;
      g_arvalid = s1.arvalid;
      g_rready  = s1.rready;
    end else begin
      g_awaddr  = s0.awaddr;
      g_awprot  = s0.awprot;
      g_awvalid = s0.awvalid;
      g_wdata   = s0.wdata;
      g_wstrb   = s0.wstrb;
      g_wvalid  = s0.wvalid;
      g_bready  = s0.bready;
      g_araddr  = s0.araddr;
      g_arprot  = s0.arprot;
      g_arvalid = s0.arvalid;
      g_rready  = s0.rready;
    end
  end

  assign in_wx = (state == WR_XFER);
  assign in_wb = (state == WR_RESP);
  assign in_ra = (state == RD_ADDR);
  assign in_rr = (state == RD_RESP);

  // Downstream valids depend only on state and the granted master, never on m ready.
  assign m.awaddr  = in_wx ? g_awaddr : '0;
  assign m.awprot  = in_wx ? g_awprot : '0;
  assign m.awvalid = in_wx && !aw_done && g_awvalid;
  assign m.wdata   = in_wx ? g_wdata : '0;
  assign m.wstrb   = in_wx ? g_wstrb : '0;
  assign m.wvalid  = in_wx && !w_done && g_wvalid;
  assign m.bready  = in_wb && g_bready;
  assign m.araddr  = in_ra ? g_araddr : '0;
  assign m.arprot  = in_ra ? g_arprot : '0;
  assign m.arvalid = in_ra && g_arvalid;
  assign m.rready  = in_rr && g_rready;

  assign aw_hs = m.awvalid && m.awready;
  assign w_hs  = m.wvalid && m.wready;
  assign b_hs  = m.bvalid && m.bready;
  assign ar_hs = m.arvalid && m.arready;
  assign r_hs  = m.rvalid && m.rready;

  assign s0.awready = in_wx && !gnt && !aw_done && m.awready;
  assign s0.wready  = in_wx && !gnt && !w_done && m.wready;
  assign s0.bvalid  = in_wb && !gnt && m.bvalid;
  assign s0.bresp   = (in_wb && !gnt) ? m.bresp : 2'b00;
  assign s0.arready = in_ra && !gnt && m.arready;
  assign s0.rvalid  = in_rr && !gnt && m.rvalid;
  assign s0.rdata   = (in_rr && !gnt) ? m.rdata : '0;
  assign s0.rresp   = (in_rr && !gnt) ? m.rresp : 2'b00;

  assign s1.awready = in_wx && gnt && !aw_done && m.awready;
  assign s1.wready  = in_wx && gnt && !w_done && m.wready;
  assign s1.bvalid  = in_wb && gnt && m.bvalid;
  assign s1.bresp   = (in_wb && gnt) ? m.bresp : 2'b00;
  assign s1.arready = in_ra && gnt && m.arready;
  assign s1.rvalid  = in_rr && gnt && m.rvalid;
  assign s1.rdata   = (in_rr && gnt) ? m.rdata : '0;
  assign s1.rresp   = (in_rr && gnt) ? m.rresp : 2'b00;

  // The downstream slave shares areset, so a reset mid-transaction needs no drain.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state   <= IDLE;
      rr_ptr  <= 2'd0;
      gnt     <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            gnt    <= pick_idx[1];
            rr_ptr <= pick_idx + 2'd1;
            state  <= pick_idx[0] ? RD_ADDR : WR_XFER;
          end
        end
        WR_XFER: begin
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            state   <= WR_RESP;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end else begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
          end
        end
        WR_RESP: begin
          if (b_hs) state <= IDLE;
        end
        RD_ADDR: begin
          if (ar_hs) state <= RD_RESP;
        end
        RD_RESP: begin
          if (r_hs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/axi_lite_arbiter_2to1.md
Name: axi_lite_arbiter_2to1

Overview:
- Shares one AXI4-Lite slave (the BRAM-backed register/memory window) between two AXI4-Lite masters, e.g. the host PCIe bridge and the local soft-core.
- Serialises accesses: one transaction (read or write) in flight at a time, granted by 4-way round-robin.
- Forwards channels combinationally once granted; the grant is held until the response handshake completes.
- Sits between the two master interfaces and the memory wrapper's `axi4_lite_if.s` port.

Parameters:
- ADDR_W, 32, address width forwarded on awaddr/araddr (memory decodes [11:0]).
- DATA_W, 32, data width; wstrb width is DATA_W/8.

Ports:
- aclk  input  1  clock.
- areset  input  1  synchronous, active-high reset.
- s0  interface  axi4_lite_if.s  requester 0 (higher initial priority).
- s1  interface  axi4_lite_if.s  requester 1.
- m  interface  axi4_lite_if.m  shared downstream slave (memory).

Behaviour:

Reset state (areset=1 at a clock edge):
- State is IDLE and rr_ptr = 0 (s0 write first).
- All s0/s1 ready/valid outputs are 0; bresp/rresp/rdata are 0.
- All m valid/ready outputs are 0.
- Mid-transaction reset aborts immediately. The downstream slave shares this reset, so no response is awaited.

Request sources, evaluated only in IDLE:
- Index 0 = s0.awvalid, 1 = s0.arvalid, 2 = s1.awvalid, 3 = s1.arvalid.
- Grant goes to the first asserted index starting at rr_ptr, cyclic.
- On grant, rr_ptr <= granted index + 1 (mod 4).
- Neither s0.wvalid nor s1.wvalid alone raises a request; W without AW waits.

FSM states: IDLE, WR_XFER, WR_RESP, RD_ADDR, RD_RESP.
- IDLE -> WR_XFER (write grant) or RD_ADDR (read grant) on the next edge; grant index and type are registered.
  - Arbitration latency: request visible in cycle N gives forwarding from cycle N+1.
- WR_XFER:
  - m.aw* = granted aw*, gated by !aw_done.
  - m.w* = granted w*, gated by !w_done.
  - Granted awready/wready = m.awready/m.wready, each gated by its done flag.
  - aw_done/w_done set on the respective handshake. AW and W may complete in any order or in the same cycle.
  - -> WR_RESP on the edge where both are done, flags included that cycle; flags are cleared.
- WR_RESP:
  - Granted bvalid/bresp = m.bvalid/m.bresp; m.bready = granted bready.
  - -> IDLE on the b handshake.
- RD_ADDR:
  - m.ar* = granted ar*; granted arready = m.arready.
  - -> RD_RESP on the ar handshake.
- RD_RESP:
  - Granted rvalid/rdata/rresp from m; m.rready = granted rready.
  - -> IDLE on the r handshake.

Non-granted requester:
- All ready/valid outputs are held 0 and data/resp outputs 0.
- Its pending valids must be held per AXI; this block never drops them.

Timing and ordering:
- Exactly one IDLE cycle separates consecutive transactions.
- Minimum occupancy: write 3 cycles (grant, aw+w, b); read 3 cycles.
- No combinational path from m ready to m valid.
- A write may be granted while the same master's read is pending; ordering is by arbiter only.
- prot fields are forwarded unmodified.
- Downstream bresp/rresp (including SLVERR/DECERR) is passed through unchanged.

Test Plan:
- Single s0 write of 0xDEADBEEF to 0x010, wstrb=0xF, AW and W in the same cycle -> m sees one aw+w handshake; s0 gets bvalid with bresp=0; s0 read of 0x010 returns rdata=0xDEADBEEF with rresp=0.
- s0 and s1 both assert awvalid+wvalid plus arvalid at the same cycle from reset -> grant order is s0W, s0R, s1W, s1R; s1 readies stay 0 until its grant.
- s1 write with W presented 3 cycles before AW, and m.awready delayed 2 cycles after m.wready -> transfer completes once; neither aw nor w is issued twice; bresp is returned to s1 only.
- Backpressure: s0 holds rready=0 for 5 cycles while m.rvalid=1 -> FSM stays in RD_RESP; rdata is stable; s1 arvalid waits; s1 is granted 2 cycles after s0's r handshake.
- areset=1 asserted while in WR_XFER with aw_done=1 -> next cycle all outputs are 0 and state is IDLE; the subsequent first grant goes to index 0 if requested.
- Continuous requests from s0 only (alternating writes and reads) for 20 transactions -> no lost or duplicated handshakes; a scoreboard of memory contents matches.
